// File: rtl/clock_reset_sequencer.sv
// Phase-clock generator and 6502 reset sequencer for the 8-bit computer.
// A single phase counter on CLOCK_50 produces cpu_phi / mem_phi / vid_phi.
// A HOLD -> STRETCH -> RUN machine keeps cpu_res asserted until the CPU has
// seen RES_PHI_CYCLES full phi cycles. A second key gives single-step mode,
// and cycle_cnt counts phi cycles since reset for LED debug.
// DIV must be a multiple of 4 and at least 8.

module clock_reset_sequencer #(
  parameter int DIV             = 50,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RES_PHI_CYCLES  = 8
) (
  input  logic        CLOCK_50,
  input  logic        res_n,
  input  logic        key_res_n,
  input  logic        key_step_n,
  input  logic        run_mode,
  output logic        cpu_phi,
  output logic        mem_phi,
  output logic        vid_phi,
  output logic        cpu_res,
  output logic [31:0] cycle_cnt
);

  // ------------------------------------------------------------------
  // Widths and phase decode points
  // ------------------------------------------------------------------
  localparam int CW  = $clog2(DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(RES_PHI_CYCLES + 1);

  localparam logic [CW-1:0]  CNT_LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_RISE_PRE = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]  CNT_HALF     = CW'(DIV / 2);
  localparam logic [CW-1:0]  CNT_Q1       = CW'(DIV / 4);
  localparam logic [CW-1:0]  CNT_Q3       = CW'((3 * DIV) / 4);
  localparam logic [DBW-1:0] DEB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  STRETCH_DONE = SW'(RES_PHI_CYCLES);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_STRETCH,
    ST_RUN
  } state_t;

  // ------------------------------------------------------------------
  // Key conditioning: bit 0 = reset key, bit 1 = step key
  // ------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] key_deb;

  assign key_raw = {key_step_n, key_res_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic           sync1_reg;
      logic           sync2_reg;
      logic           deb_reg;
      logic [DBW-1:0] deb_cnt_reg;

      // Two-flop synchronizer, then accept a new level only after it has
      // been stable (and different) for DEBOUNCE_CYCLES consecutive cycles.
      always_ff @(posedge CLOCK_50) begin
        if (!res_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          deb_reg     <= 1'b1;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != deb_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
              deb_reg     <= sync2_reg;
              deb_cnt_reg <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DBW'(1);
            end
          end else begin
            // Any bounce back to the accepted level restarts the count.
            deb_cnt_reg <= '0;
          end
        end
      end

      assign key_deb[gi] = deb_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Step key falling-edge detect on the debounced level
  // ------------------------------------------------------------------
  logic step_prev_reg;
  logic step_fall;

  // Remember last debounced step level to find its falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      step_prev_reg <= 1'b1;
    end else begin
      step_prev_reg <= key_deb[1];
    end
  end

  assign step_fall = step_prev_reg & ~key_deb[1];

  // ------------------------------------------------------------------
  // Phase counter / reset sequencer state
  // ------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [SW-1:0] stretch_reg, stretch_next;
  logic [31:0]   cycle_cnt_reg, cycle_cnt_next;
  logic          cpu_phi_reg, cpu_phi_next;
  logic          mem_phi_reg, mem_phi_next;
  logic          vid_phi_reg, vid_phi_next;
  logic          cpu_res_reg, cpu_res_next;

  logic advance;
  logic phi_rise;
  logic phi_wrap;

  // The counter moves whenever it is free running (HOLD/STRETCH or
  // run_mode=1), while a period is already under way (cnt != 0, which also
  // finishes a period after run_mode drops), or on a step edge while parked.
  // A step edge in any other situation has no effect, so it is never queued.
  assign advance  = (state_reg != ST_RUN) || run_mode ||
                    (cnt_reg != '0) || step_fall;
  assign phi_rise = advance && (cnt_reg == CNT_RISE_PRE);
  assign phi_wrap = advance && (cnt_reg == CNT_LAST);

  // Next-state: phase counter, reset FSM, stretch count and cycle counter.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    stretch_next   = stretch_reg;
    cycle_cnt_next = cycle_cnt_reg;

    if (advance) begin
      cnt_next = phi_wrap ? '0 : cnt_reg + CW'(1);
    end

    case (state_reg)
      ST_HOLD: begin
        stretch_next = '0;
        if (key_deb[0]) begin
          state_next = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        if (phi_rise && (stretch_reg != STRETCH_DONE)) begin
          stretch_next = stretch_reg + SW'(1);
        end
        // Release only on a period boundary so the CPU starts on a whole cycle.
        if (phi_wrap && (stretch_reg == STRETCH_DONE)) begin
          state_next   = ST_RUN;
          stretch_next = '0;
        end
      end
      ST_RUN: begin
        if (phi_rise) begin
          cycle_cnt_next = cycle_cnt_reg + 32'd1;
        end
      end
      default: begin
        state_next   = ST_HOLD;
        stretch_next = '0;
      end
    endcase

    // A pressed reset key wins over everything and restarts the stretch.
    if (!key_deb[0]) begin
      state_next   = ST_HOLD;
      stretch_next = '0;
    end

    if (state_next != ST_RUN) begin
      cycle_cnt_next = '0;
    end

    cpu_phi_next = (cnt_next >= CNT_HALF);
    mem_phi_next = (cnt_next >= CNT_Q1) && (cnt_next < CNT_Q3);
    vid_phi_next = ~cpu_phi_next;
    cpu_res_next = (state_next != ST_RUN);
  end

  // State and output registers; outputs are decoded from the next count so
  // they line up with cnt_reg with no logic after the flops.
  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      state_reg     <= ST_HOLD;
      cnt_reg       <= '0;
      stretch_reg   <= '0;
      cycle_cnt_reg <= '0;
      cpu_phi_reg   <= 1'b0;
      mem_phi_reg   <= 1'b0;
      vid_phi_reg   <= 1'b1;
      cpu_res_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stretch_reg   <= stretch_next;
      cycle_cnt_reg <= cycle_cnt_next;
      cpu_phi_reg   <= cpu_phi_next;
      mem_phi_reg   <= mem_phi_next;
      vid_phi_reg   <= vid_phi_next;
      cpu_res_reg   <= cpu_res_next;
    end
  end

  assign cpu_phi   = cpu_phi_reg;
  assign mem_phi   = mem_phi_reg;
  assign vid_phi   = vid_phi_reg;
  assign cpu_res   = cpu_res_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer with DIV=8, DEBOUNCE_CYCLES=4,
// RES_PHI_CYCLES=3. A cycle-level reference model is stepped alongside the
// DUT; directed table vectors and multi-cycle sequences add fixed checks.

module tb_clock_reset_sequencer;

  localparam int DIV = 8;
  localparam int DEB = 4;
  localparam int RES = 3;

  localparam int M_HOLD    = 0;
  localparam int M_STRETCH = 1;
  localparam int M_RUN     = 2;

  logic        clk;
  logic        res_n;
  logic        key_res_n;
  logic        key_step_n;
  logic        run_mode;
  logic        cpu_phi;
  logic        mem_phi;
  logic        vid_phi;
  logic        cpu_res;
  logic [31:0] cycle_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  clock_reset_sequencer #(
    .DIV            (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .RES_PHI_CYCLES (RES)
  ) dut (
    .CLOCK_50  (clk),
    .res_n     (res_n),
    .key_res_n (key_res_n),
    .key_step_n(key_step_n),
    .run_mode  (run_mode),
    .cpu_phi   (cpu_phi),
    .mem_phi   (mem_phi),
    .vid_phi   (vid_phi),
    .cpu_res   (cpu_res),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keys: raw -> two-stage delay -> accepted when the last DEB delayed
  // samples all disagree with the current accepted level.
  bit          m_s1   [2];
  bit          m_s2   [2];
  bit          m_deb  [2];
  bit          m_hist [2][DEB];
  bit          m_step_prev;
  int          m_mode;
  int          m_pos;
  int          m_rises;
  logic [31:0] m_cycles;

  task automatic model_step();
    bit step_fall, moving, rise, wrap, all_diff;
    int new_mode;
    if (!res_n) begin
      m_mode = M_HOLD; m_pos = 0; m_rises = 0; m_cycles = 32'd0; m_step_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_deb[k] = 1'b1;
        for (int j = 0; j < DEB; j++) m_hist[k][j] = 1'b1;
      end
      return;
    end
    step_fall = m_step_prev && !m_deb[1];
    // parked only when in RUN, step mode, at position 0 and no step request
    moving = !(m_mode == M_RUN && !run_mode && m_pos == 0 && !step_fall);
    rise   = moving && (m_pos == DIV / 2 - 1);
    wrap   = moving && (m_pos == DIV - 1);
    new_mode = m_mode;
    if (m_mode == M_HOLD) begin
      m_rises  = 0;
      new_mode = M_STRETCH;
    end else if (m_mode == M_STRETCH) begin
      if (wrap && m_rises >= RES) begin
        new_mode = M_RUN;
        m_rises  = 0;
      end else if (rise) begin
        m_rises = m_rises + 1;
      end
    end else if (rise) begin
      m_cycles = m_cycles + 32'd1;
    end
    if (!m_deb[0]) begin
      new_mode = M_HOLD;
      m_rises  = 0;
    end
    if (new_mode != M_RUN) m_cycles = 32'd0;
    m_mode = new_mode;
    if (moving) m_pos = (m_pos + 1) % DIV;
    m_step_prev = m_deb[1];
    for (int k = 0; k < 2; k++) begin
      for (int j = DEB - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = m_s2[k];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[k][j] == m_deb[k]) all_diff = 1'b0;
      if (all_diff) m_deb[k] = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = (k == 0) ? key_res_n : key_step_n;
    end
  endtask

  // Compare all outputs against the model after one clock.
  task automatic tick();
    bit e_cpu, e_mem, e_vid, e_res;
    model_step();
    @(posedge clk);
    @(negedge clk);
    e_cpu = (m_pos >= DIV / 2);
    e_mem = (m_pos >= DIV / 4) && (m_pos < (3 * DIV) / 4);
    e_vid = !e_cpu;
    e_res = (m_mode != M_RUN);
    n_vec++;
    if (cpu_phi !== e_cpu || mem_phi !== e_mem || vid_phi !== e_vid ||
        cpu_res !== e_res || cycle_cnt !== m_cycles) begin
      n_miss++;
      $display("FAIL model t=%0t: got phi=%b mem=%b vid=%b res=%b cyc=%0d, expected phi=%b mem=%b vid=%b res=%b cyc=%0d",
               $time, cpu_phi, mem_phi, vid_phi, cpu_res, cycle_cnt,
               e_cpu, e_mem, e_vid, e_res, m_cycles);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("check %s = 0x%08h", name, act);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          res_n;
    bit          run_mode;
    int          cycles;
    bit          e_cpu;
    bit          e_mem;
    bit          e_vid;
    bit          e_res;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, rises, base;
    bit prev, seen;

    // {res_n, run_mode, clocks, cpu_phi, mem_phi, vid_phi, cpu_res, cycle_cnt}
    // Release edge E0 leaves cnt=1; after edge Ek cnt=(k+1)%8.
    tbl[0] = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0}; // in reset
    tbl[1] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0}; // cnt 1
    tbl[2] = '{1'b1, 1'b1,  2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0}; // cnt 3: mem leads
    tbl[3] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0}; // cnt 4
    tbl[4] = '{1'b1, 1'b1,  2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0}; // cnt 6
    tbl[5] = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0}; // cnt 0
    tbl[6] = '{1'b1, 1'b1, 15, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0}; // 23 clocks: still reset
    tbl[7] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}; // 24 clocks: cpu_res falls
    tbl[8] = '{1'b1, 1'b1,  4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1}; // first rise counted
    tbl[9] = '{1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2};

    res_n = 1'b0; key_res_n = 1'b1; key_step_n = 1'b1; run_mode = 1'b1;

    for (int i = 0; i < 10; i++) begin
      res_n = tbl[i].res_n;
      run_mode = tbl[i].run_mode;
      repeat (tbl[i].cycles) tick();
      n_vec++;
      if (cpu_phi !== tbl[i].e_cpu || mem_phi !== tbl[i].e_mem || vid_phi !== tbl[i].e_vid ||
          cpu_res !== tbl[i].e_res || cycle_cnt !== tbl[i].e_cyc) begin
        n_miss++;
        $display("FAIL table[%0d]: got phi=%b mem=%b vid=%b res=%b cyc=%0d, expected phi=%b mem=%b vid=%b res=%b cyc=%0d",
                 i, cpu_phi, mem_phi, vid_phi, cpu_res, cycle_cnt, tbl[i].e_cpu,
                 tbl[i].e_mem, tbl[i].e_vid, tbl[i].e_res, tbl[i].e_cyc);
      end else begin
        $display("table[%0d] phi=%b mem=%b vid=%b res=%b cyc=%0d", i, cpu_phi, mem_phi,
                 vid_phi, cpu_res, cycle_cnt);
      end
    end

    // Bounce on the reset key shorter than the debounce window
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      key_res_n = ((t / 2) % 2) != 0;
      tick();
      if (cpu_res !== 1'b0) seen = 1'b1;
    end
    key_res_n = 1'b1;
    chk("bounce_res_stays_low", {31'd0, seen}, 32'd0);
    repeat (8) tick();

    // Reset key held: asserts within sync + debounce + register
    key_res_n = 1'b0;
    n = 0;
    while (cpu_res !== 1'b1 && n < 20) begin tick(); n++; end
    chk("key_res_assert_latency_le7", {31'd0, (cpu_res === 1'b1 && n <= 7)}, 32'd1);
    repeat (10) tick();
    chk("key_res_held_res", {31'd0, cpu_res}, 32'd1);

    // Release: three phi rising edges in STRETCH, then release at a wrap
    key_res_n = 1'b1;
    repeat (7) tick();
    prev = cpu_phi; rises = 0; n = 0;
    while (cpu_res !== 1'b0 && n < 100) begin
      tick(); n++;
      if (!prev && cpu_phi) rises++;
      prev = cpu_phi;
    end
    chk("stretch_rises", rises, 3);
    chk("release_phi_low", {31'd0, cpu_phi}, 32'd0);
    chk("release_mem_low", {31'd0, mem_phi}, 32'd0);
    chk("release_cyc_zero", cycle_cnt, 32'd0);

    // Step mode idle: parked, no counting
    run_mode = 1'b0;
    repeat (10) tick();
    base = m_cycles;
    hi = 0;
    repeat (100) begin tick(); hi += cpu_phi; end
    chk("idle_phi_high_clocks", hi, 0);
    chk("idle_cycle_cnt", cycle_cnt, base);

    // One step press; a second short press inside the period must not add one
    base = m_cycles; hi = 0; rises = 0; prev = cpu_phi;
    for (int t = 0; t < 40; t++) begin
      key_step_n = (t < 10) ? 1'b0 : (t < 12) ? 1'b1 : (t < 22) ? 1'b0 : 1'b1;
      tick();
      hi += cpu_phi;
      if (!prev && cpu_phi) rises++;
      prev = cpu_phi;
    end
    chk("step_phi_high_clocks", hi, 4);
    chk("step_pulses", rises, 1);
    chk("step_cycle_cnt", cycle_cnt, base + 1);
    repeat (10) tick();

    // Mode switch at cnt=5: period completes, then parks
    run_mode = 1'b1;
    n = 0;
    while (m_pos != 5 && n < 20) begin tick(); n++; end
    chk("modesw_at5_phi", {31'd0, cpu_phi}, 32'd1);
    run_mode = 1'b0;
    tick(); chk("modesw_cnt6_phi", {31'd0, cpu_phi}, 32'd1);
    tick(); chk("modesw_cnt7_phi", {31'd0, cpu_phi}, 32'd1);
    tick(); chk("modesw_park_phi", {31'd0, cpu_phi}, 32'd0);
    repeat (10) tick();
    chk("modesw_parked_phi", {31'd0, cpu_phi}, 32'd0);

    // Reset mid-step
    key_step_n = 1'b0;
    n = 0;
    while (cpu_phi !== 1'b1 && n < 30) begin tick(); n++; end
    chk("midstep_phi_seen", {31'd0, cpu_phi}, 32'd1);
    res_n = 1'b0; key_step_n = 1'b1;
    tick();
    chk("midstep_rst_phi", {31'd0, cpu_phi}, 32'd0);
    chk("midstep_rst_res", {31'd0, cpu_res}, 32'd1);
    chk("midstep_rst_cyc", cycle_cnt, 32'd0);
    res_n = 1'b1;
    n = 0; hi = 0;
    while (cpu_res !== 1'b0 && n < 60) begin tick(); n++; hi += cpu_phi; end
    chk("midstep_stretch_clocks", n, 24);
    chk("midstep_stretch_phi_high", hi, 12);
    repeat (10) tick();
    chk("midstep_then_parked", {31'd0, cpu_phi}, 32'd0);

    // Wrap of cycle_cnt
    run_mode = 1'b1;
    repeat (20) tick();
    force dut.cycle_cnt_reg = 32'hFFFF_FFFE;
    m_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_reg;
    repeat (16) tick();
    chk("cycle_cnt_wrap", cycle_cnt, 32'd0);

    // Randomized stimulus against the model
    for (int t = 0; t < 4000; t++) begin
      res_n = ($urandom_range(0, 299) != 0);
      if (key_res_n) key_res_n = ($urandom_range(0, 199) != 0);
      else key_res_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) key_step_n = ~key_step_n;
      if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
      tick();
    end
    $display("random phase done, model position %0d", m_pos);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clock_reset_sequencer.md
Name: clock_reset_sequencer

Overview:
Upstream of the 8-bit computer top level. It generates the cpu_phi, mem_phi and vid_phi phase clocks from CLOCK_50 and produces the 6502 reset from a debounced pushbutton. The reset is stretched so the CPU always sees a minimum number of full phi cycles. It also provides a single-step mode driven by a second pushbutton, and a phi-cycle counter for LED debug.

Parameters:
DIV, 50 (must be a multiple of 4, at least 8), CLOCK_50 cycles per cpu_phi period.
DEBOUNCE_CYCLES, 1000000, number of stable CLOCK_50 cycles required before a key level change is accepted.
RES_PHI_CYCLES, 8, number of cpu_phi rising edges cpu_res stays high after the reset source releases.

Ports:
CLOCK_50  in  1  sole clock.
res_n  in  1  global reset; synchronous, active-low.
key_res_n  in  1  raw KEY[0]; asynchronous, active-low, bouncy.
key_step_n  in  1  raw KEY[1]; asynchronous, active-low, bouncy.
run_mode  in  1  1 = free run, 0 = single step.
cpu_phi  out  1  CPU phase clock.
mem_phi  out  1  memory clock, a quarter period ahead of cpu_phi.
vid_phi  out  1  video phase, the complement of cpu_phi.
cpu_res  out  1  active-high reset to the CPU.
cycle_cnt  out  32  cpu_phi rising edges since cpu_res deasserted.

Behaviour:
- One clock, CLOCK_50. res_n is sampled on the rising edge. All outputs are registered; there is no combinational decode on the outputs.
- Key inputs:
  - Each key passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the debounce counter.
  - Reset state: debounced levels = 1, counters = 0.
- Phase counter cnt runs 0..DIV-1 and wraps. Decodes:
  - cpu_phi = 1 when cnt is in [DIV/2, DIV-1].
  - mem_phi = 1 when cnt is in [DIV/4, 3*DIV/4-1].
  - vid_phi = NOT cpu_phi.
- Counter advance:
  - cnt advances every cycle when run_mode=1, or when the FSM is not in RUN.
  - In step mode (run_mode=0, RUN) cnt parks at 0.
  - A debounced falling edge of key_step starts exactly one period: DIV cycles, ending parked at 0.
  - A step edge during an active period, or outside RUN, is dropped, not queued.
  - run_mode 1->0 mid-period: the current period completes, then cnt parks at 0.
  - run_mode 0->1: cnt advances on the next cycle.
- Reset FSM states:
  - HOLD: cpu_res=1. Entered on res_n=0 from any state, or from any state while debounced key_res=0.
  - STRETCH: cpu_res=1. Entered from HOLD when res_n=1 and debounced key_res=1. Counts cpu_phi rising edges (the cnt transition DIV/2-1 -> DIV/2).
  - RUN: cpu_res=0. Entered when the count reaches RES_PHI_CYCLES and cnt wraps DIV-1 -> 0. cpu_res falls on that same edge.
  - In HOLD and STRETCH the phase clock free-runs regardless of run_mode.
  - Re-entering HOLD mid-STRETCH or mid-step clears the stretch count and aborts the step.
- Values while res_n=0:
  - cnt=0, FSM=HOLD.
  - cpu_phi=0, mem_phi=0, vid_phi=1, cpu_res=1, cycle_cnt=0.
- cycle_cnt:
  - Held at 0 while cpu_res=1.
  - In RUN, increments by 1 on every cpu_phi rising edge.
  - Wraps 0xFFFFFFFF -> 0.

Test Plan (DIV=8, DEBOUNCE_CYCLES=4, RES_PHI_CYCLES=3):
- Reset, free run:
  - Stimulus: res_n=0 for 3 clocks, then res_n=1, run_mode=1.
  - During reset: cpu_phi=0, mem_phi=0, vid_phi=1, cpu_res=1, cycle_cnt=0.
  - After release: cpu_phi high for 4 of every 8 clocks, mem_phi rising 2 clocks before cpu_phi.
  - cpu_res falls exactly 24 clocks after release.
- Bounce rejection:
  - Stimulus: key_res_n toggles every 2 clocks for 20 clocks -> cpu_res stays 0.
  - Stimulus: key_res_n held low -> cpu_res=1 within 2 sync + 4 debounce clocks (+1 register).
  - Release -> cpu_res=0 after 3 more cpu_phi rising edges, at a cnt wrap.
- Single step:
  - Stimulus: run_mode=0 in RUN, idle 100 clocks -> cpu_phi=0 throughout, cycle_cnt unchanged.
  - Stimulus: one key_step_n press held 10 clocks -> exactly one 4-clock cpu_phi pulse, cycle_cnt +1.
  - Second press during that period -> no extra pulse.
- Mode switch: run_mode 1->0 at cnt=5 -> the period finishes (cpu_phi stays high through cnt 7), then parks at cnt=0 with cpu_phi=0.
- Reset mid-step: res_n=0 while a step period has cpu_phi=1 -> next cycle cpu_phi=0, cpu_res=1, cycle_cnt=0; after release the clock free-runs through STRETCH despite run_mode=0.
- Wrap: preload cycle_cnt to 0xFFFFFFFE through a bench force, run 2 phi rising edges -> 0x00000000.
